// File: rtl/operand_forward_unit_pkg.sv
// Shared definitions for the operand bypass stage.
// Supplies the default data/tag widths and the saturating adder used by the
// optional statistics counters (enabled with FWD_STATS_EN).
`ifndef DWIDTH
`define DWIDTH 32
`endif
`ifndef AWIDTH_DEFAULT
`define AWIDTH_DEFAULT 5
`endif

package operand_forward_unit_pkg;

  localparam int STAT_W = 32;
  localparam logic [STAT_W-1:0] STAT_MAX = '1;

  // Adds two counter values and pins the result at all-ones instead of wrapping.
  function automatic logic [STAT_W-1:0] sat_add(input logic [STAT_W-1:0] a,
                                                input logic [STAT_W-1:0] b);
    logic [STAT_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[STAT_W] ? STAT_MAX : sum[STAT_W-1:0];
  endfunction

endpackage

// File: rtl/operand_forward_unit_select.sv
// One operand channel of the bypass stage: priority match of a register tag
// against the in-flight result sources. Source 0 is the youngest and wins.
// Register 0 is hard-wired and is never forwarded.
import operand_forward_unit_pkg::*;

module fwd_select #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 5,
  parameter int NSRC   = 3,
  parameter int SELW   = 2
) (
  input  logic [AWIDTH-1:0]      tag,
  input  logic [DWIDTH-1:0]      rf_data,
  input  logic [NSRC-1:0]        src_valid,
  input  logic [NSRC*AWIDTH-1:0] src_tag,
  input  logic [NSRC*DWIDTH-1:0] src_data,
  input  logic [NSRC-1:0]        src_pend,
  output logic [DWIDTH-1:0]      data,
  output logic [SELW-1:0]        sel,
  output logic                   blocked
);

  logic found;

  // Scan youngest to oldest; the first live match decides data, code and
  // whether the channel must wait for a result still in flight.
  always_comb begin
    data    = rf_data;
    sel     = '0;
    blocked = 1'b0;
    found   = 1'b0;
    for (int k = 0; k < NSRC; k++) begin
      if (!found && src_valid[k] && (tag != '0) &&
          (src_tag[k*AWIDTH +: AWIDTH] == tag)) begin
        found   = 1'b1;
        data    = src_data[k*DWIDTH +: DWIDTH];
        sel     = SELW'(k + 1);
        blocked = src_pend[k];
      end
    end
  end

endmodule

// File: rtl/operand_forward_unit.sv
// Operand bypass stage ahead of the ALU lanes. Each channel selects the
// youngest matching in-flight result (or the register-file value), the group
// stalls while any chosen result is still pending, and the selections are
// registered behind a valid/ready handshake.
// Optional feature macro: FWD_STATS_EN adds fwd_cnt and stall_cnt outputs.
import operand_forward_unit_pkg::*;

module operand_forward_unit #(
  parameter int DWIDTH = `DWIDTH,
  parameter int AWIDTH = `AWIDTH_DEFAULT,
  parameter int NOPS   = 4,
  parameter int NSRC   = 3,
  localparam int SELW  = $clog2(NSRC + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NOPS*AWIDTH-1:0] in_tag,
  input  logic [NOPS*DWIDTH-1:0] in_data,
  input  logic [NSRC-1:0]        src_valid,
  input  logic [NSRC*AWIDTH-1:0] src_tag,
  input  logic [NSRC*DWIDTH-1:0] src_data,
  input  logic [NSRC-1:0]        src_pend,
  output logic                   stall,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NOPS*DWIDTH-1:0] out_data,
  output logic [NOPS*SELW-1:0]   out_sel
`ifdef FWD_STATS_EN
  ,
  output logic [31:0]            fwd_cnt,
  output logic [31:0]            stall_cnt
`endif
);

  logic [NOPS*DWIDTH-1:0] sel_data;
  logic [NOPS*SELW-1:0]   sel_code;
  logic [NOPS-1:0]        chan_blocked;
  logic                   capture;

  for (genvar i = 0; i < NOPS; i++) begin : g_chan
    fwd_select #(
      .DWIDTH(DWIDTH),
      .AWIDTH(AWIDTH),
      .NSRC  (NSRC),
      .SELW  (SELW)
    ) u_sel (
      .tag      (in_tag[i*AWIDTH +: AWIDTH]),
      .rf_data  (in_data[i*DWIDTH +: DWIDTH]),
      .src_valid(src_valid),
      .src_tag  (src_tag),
      .src_data (src_data),
      .src_pend (src_pend),
      .data     (sel_data[i*DWIDTH +: DWIDTH]),
      .sel      (sel_code[i*SELW +: SELW]),
      .blocked  (chan_blocked[i])
    );
  end

  // A pending winner on any channel holds the whole group back; the output
  // slot is free when empty or being drained this cycle.
  always_comb begin
    stall    = in_valid && (|chan_blocked);
    in_ready = (!out_valid || out_ready) && !stall;
    capture  = in_valid && in_ready;
  end

  // Output register: load on capture, drop valid once consumed, else hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
    end else if (capture) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_sel   <= sel_code;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef FWD_STATS_EN
  logic [31:0] fwd_inc;

  // Number of channels in the current group that take a forwarded value.
  always_comb begin
    fwd_inc = '0;
    for (int i = 0; i < NOPS; i++) begin
      if (sel_code[i*SELW +: SELW] != '0) begin
        fwd_inc = fwd_inc + 32'd1;
      end
    end
  end

  // Saturating usage counters: forwarded channels per capture, stalled cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_cnt   <= '0;
      stall_cnt <= '0;
    end else begin
      if (capture) begin
        fwd_cnt <= sat_add(fwd_cnt, fwd_inc);
      end
      if (stall) begin
        stall_cnt <= sat_add(stall_cnt, 32'd1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_operand_forward_unit.sv
// Self-checking bench for operand_forward_unit: fixed vectors, hand-written
// stall/backpressure/reset sequences and a randomized run, all checked against
// a behavioural model of the bypass rules and the output handshake.
`timescale 1ns/1ps

module tb_operand_forward_unit;

  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int NOPS = 4;
  localparam int NSRC = 3;
  localparam int SELW = $clog2(NSRC + 1);

  logic                 clk;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic [NOPS*AW-1:0]   in_tag;
  logic [NOPS*DW-1:0]   in_data;
  logic [NSRC-1:0]      src_valid;
  logic [NSRC*AW-1:0]   src_tag;
  logic [NSRC*DW-1:0]   src_data;
  logic [NSRC-1:0]      src_pend;
  logic                 stall;
  logic                 out_valid;
  logic                 out_ready;
  logic [NOPS*DW-1:0]   out_data;
  logic [NOPS*SELW-1:0] out_sel;
`ifdef FWD_STATS_EN
  logic [31:0]          fwd_cnt;
  logic [31:0]          stall_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Model state of the output register and counters
  logic                 m_valid;
  logic [NOPS*DW-1:0]   m_data;
  logic [NOPS*SELW-1:0] m_sel;
  logic [31:0]          m_fwd;
  logic [31:0]          m_stl;

  typedef struct {
    logic [NOPS*AW-1:0]   tag;
    logic [NOPS*DW-1:0]   data;
    logic [NSRC-1:0]      sv;
    logic [NSRC*AW-1:0]   st;
    logic [NSRC*DW-1:0]   sd;
    logic [NSRC-1:0]      sp;
    logic [NOPS*DW-1:0]   exp_data;
    logic [NOPS*SELW-1:0] exp_sel;
  } vec_t;

  vec_t vecs[5];

  operand_forward_unit #(
    .DWIDTH(DW),
    .AWIDTH(AW),
    .NOPS  (NOPS),
    .NSRC  (NSRC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_tag   (in_tag),
    .in_data  (in_data),
    .src_valid(src_valid),
    .src_tag  (src_tag),
    .src_data (src_data),
    .src_pend (src_pend),
    .stall    (stall),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_sel  (out_sel)
`ifdef FWD_STATS_EN
    ,
    .fwd_cnt  (fwd_cnt),
    .stall_cnt(stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [127:0] act,
                              input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference selection: gather every live matching source, the first
  // (youngest) one is used; otherwise the register-file value.
  task automatic ref_select(output logic [NOPS*DW-1:0] d,
                            output logic [NOPS*SELW-1:0] s,
                            output logic blk, output int nfwd);
    int q[$];
    d = '0; s = '0; blk = 1'b0; nfwd = 0;
    for (int i = 0; i < NOPS; i++) begin
      q.delete();
      for (int k = 0; k < NSRC; k++) begin
        if (src_valid[k] && in_tag[i*AW +: AW] != 0 &&
            src_tag[k*AW +: AW] == in_tag[i*AW +: AW]) q.push_back(k);
      end
      if (q.size() == 0) begin
        d[i*DW +: DW] = in_data[i*DW +: DW];
      end else begin
        d[i*DW +: DW]     = src_data[q[0]*DW +: DW];
        s[i*SELW +: SELW] = SELW'(q[0] + 1);
        if (src_pend[q[0]]) blk = 1'b1;
        nfwd++;
      end
    end
  endtask

  // One clock: check combinational handshake, advance model, check outputs.
  task automatic tick();
    logic [NOPS*DW-1:0]   d;
    logic [NOPS*SELW-1:0] s;
    logic                 blk;
    int                   nf;
    logic                 exp_stall;
    logic                 exp_ready;
    longint               sum;
    #2;
    ref_select(d, s, blk, nf);
    exp_stall = in_valid && blk;
    exp_ready = (!m_valid || out_ready) && !exp_stall;
    if (!rst) begin
      check_output("stall", 128'(stall), 128'(exp_stall));
      check_output("in_ready", 128'(in_ready), 128'(exp_ready));
    end
    if (rst) begin
      m_valid = 1'b0; m_data = '0; m_sel = '0; m_fwd = '0; m_stl = '0;
    end else begin
      if (exp_stall && m_stl != 32'hFFFF_FFFF) m_stl = m_stl + 32'd1;
      if (in_valid && exp_ready) begin
        m_valid = 1'b1;
        m_data  = d;
        m_sel   = s;
        sum     = longint'(m_fwd) + longint'(nf);
        m_fwd   = (sum > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : sum[31:0];
      end else if (m_valid && out_ready) begin
        m_valid = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    check_output("out_valid", 128'(out_valid), 128'(m_valid));
    check_output("out_data", 128'(out_data), 128'(m_data));
    check_output("out_sel", 128'(out_sel), 128'(m_sel));
`ifdef FWD_STATS_EN
    check_output("fwd_cnt", 128'(fwd_cnt), 128'(m_fwd));
    check_output("stall_cnt", 128'(stall_cnt), 128'(m_stl));
`endif
  endtask

  task automatic apply_stimulus(input vec_t v);
    in_tag    = v.tag;
    in_data   = v.data;
    src_valid = v.sv;
    src_tag   = v.st;
    src_data  = v.sd;
    src_pend  = v.sp;
  endtask

  task automatic clear_inputs();
    in_valid = 1'b0; in_tag = '0; in_data = '0;
    src_valid = '0; src_tag = '0; src_data = '0; src_pend = '0;
  endtask

  initial begin
    m_valid = 1'b0; m_data = '0; m_sel = '0; m_fwd = '0; m_stl = '0;
    rst = 1'b1; out_ready = 1'b0;
    clear_inputs();

    // Channel order in concatenations is ch3..ch0 / src2..src0
    vecs[0] = '{tag: {5'd0, 5'd0, 5'd0, 5'd5},
                data: {32'h3, 32'h2, 32'h1, 32'h11},
                sv: 3'b000, st: '0, sd: '0, sp: 3'b000,
                exp_data: {32'h3, 32'h2, 32'h1, 32'h11},
                exp_sel: {2'd0, 2'd0, 2'd0, 2'd0}};
    vecs[1] = '{tag: {5'd9, 5'd5, 5'd9, 5'd5},
                data: {32'h33, 32'h22, 32'h44, 32'h11},
                sv: 3'b101, st: {5'd5, 5'd0, 5'd5},
                sd: {32'hC0, 32'hB0, 32'hA0}, sp: 3'b000,
                exp_data: {32'h33, 32'hA0, 32'h44, 32'hA0},
                exp_sel: {2'd0, 2'd1, 2'd0, 2'd1}};
    vecs[2] = '{tag: {5'd0, 5'd0, 5'd0, 5'd0},
                data: {32'h3, 32'h2, 32'h1, 32'h0},
                sv: 3'b001, st: {5'd0, 5'd0, 5'd0},
                sd: {32'h0, 32'h0, 32'hFF}, sp: 3'b000,
                exp_data: {32'h3, 32'h2, 32'h1, 32'h0},
                exp_sel: {2'd0, 2'd0, 2'd0, 2'd0}};
    vecs[3] = '{tag: {5'd3, 5'd2, 5'd1, 5'd3},
                data: {32'h4, 32'h3, 32'h2, 32'h1},
                sv: 3'b110, st: {5'd3, 5'd2, 5'd3},
                sd: {32'hC3, 32'hB2, 32'hA3}, sp: 3'b000,
                exp_data: {32'hC3, 32'hB2, 32'h2, 32'hC3},
                exp_sel: {2'd3, 2'd2, 2'd0, 2'd3}};
    vecs[4] = '{tag: {5'd0, 5'd0, 5'd0, 5'd6},
                data: {32'h0, 32'h0, 32'h0, 32'h16},
                sv: 3'b010, st: {5'd0, 5'd6, 5'd6},
                sd: {32'h0, 32'hB6, 32'hA6}, sp: 3'b001,
                exp_data: {32'h0, 32'h0, 32'h0, 32'hB6},
                exp_sel: {2'd0, 2'd0, 2'd0, 2'd2}};

    tick();
    tick();
    check_output("reset_out_valid", 128'(out_valid), 128'(0));
    check_output("reset_out_data", 128'(out_data), 128'(0));
    check_output("reset_out_sel", 128'(out_sel), 128'(0));

    // Ready on the very first cycle out of reset
    rst = 1'b0; out_ready = 1'b1; in_valid = 1'b1;
    #1;
    check_output("first_in_ready", 128'(in_ready), 128'(1));

    // Table-driven selection vectors
    for (int v = 0; v < 5; v++) begin
      apply_stimulus(vecs[v]);
      in_valid = 1'b1;
      tick();
      check_output($sformatf("vec%0d_data", v), 128'(out_data), 128'(vecs[v].exp_data));
      check_output($sformatf("vec%0d_sel", v), 128'(out_sel), 128'(vecs[v].exp_sel));
      check_output($sformatf("vec%0d_valid", v), 128'(out_valid), 128'(1));
    end

    // Pending source stalls the group for two cycles, then forwards
    clear_inputs();
    in_valid = 1'b1; in_tag = {5'd0, 5'd0, 5'd0, 5'd7};
    src_valid = 3'b001; src_tag = {5'd0, 5'd0, 5'd7};
    src_data = {32'h0, 32'h0, 32'h77}; src_pend = 3'b001;
    for (int c = 0; c < 2; c++) begin
      tick();
      check_output("pend_stall", 128'(stall), 128'(1));
      check_output("pend_in_ready", 128'(in_ready), 128'(0));
    end
    src_pend = 3'b000;
    tick();
    check_output("pend_release_data", 128'(out_data[31:0]), 128'(32'h77));
    check_output("pend_release_sel", 128'(out_sel[1:0]), 128'(1));

    // Younger pending match is not overridden by an older ready one
    src_valid = 3'b011; src_tag = {5'd0, 5'd4, 5'd4};
    src_data = {32'h0, 32'hB4, 32'hA4}; src_pend = 3'b001;
    in_tag = {5'd0, 5'd0, 5'd0, 5'd4};
    tick();
    check_output("young_pend_stall", 128'(stall), 128'(1));
    src_pend = 3'b000;
    tick();
    check_output("young_release_data", 128'(out_data[31:0]), 128'(32'hA4));

    // Backpressure: held output stays stable, then back-to-back acceptance
    clear_inputs();
    in_valid = 1'b1; out_ready = 1'b1;
    in_data = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    tick();
    out_ready = 1'b0;
    in_data = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
    for (int c = 0; c < 3; c++) begin
      tick();
      check_output("bp_hold_data", 128'(out_data), 128'({32'hA3, 32'hA2, 32'hA1, 32'hA0}));
      check_output("bp_in_ready", 128'(in_ready), 128'(0));
    end
    out_ready = 1'b1;
    tick();
    check_output("b2b_group_b", 128'(out_data), 128'({32'hB3, 32'hB2, 32'hB1, 32'hB0}));
    in_data = {32'hC3, 32'hC2, 32'hC1, 32'hC0};
    tick();
    check_output("b2b_group_c", 128'(out_data), 128'({32'hC3, 32'hC2, 32'hC1, 32'hC0}));
    check_output("b2b_valid", 128'(out_valid), 128'(1));
    in_valid = 1'b0;
    tick();
    check_output("drain_valid", 128'(out_valid), 128'(0));

    // Reset while a group is held drops it
    in_valid = 1'b1; out_ready = 1'b0; in_data = {4{32'h5A}};
    tick();
    rst = 1'b1;
    tick();
    check_output("midrst_valid", 128'(out_valid), 128'(0));
    check_output("midrst_data", 128'(out_data), 128'(0));
    rst = 1'b0;

    // Randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NOPS; i++) begin
        in_tag[i*AW +: AW]  = AW'($urandom_range(0, 3));
        in_data[i*DW +: DW] = $urandom;
      end
      for (int k = 0; k < NSRC; k++) begin
        src_valid[k]         = ($urandom_range(0, 2) != 0);
        src_tag[k*AW +: AW]  = AW'($urandom_range(0, 3));
        src_data[k*DW +: DW] = $urandom;
        src_pend[k]          = ($urandom_range(0, 4) == 0);
      end
      tick();
    end

`ifdef FWD_STATS_EN
    // Counter scenario: 4 groups x 3 forwarded channels, plus 2 stall cycles
    clear_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0; out_ready = 1'b1;
    in_valid = 1'b1; in_tag = {5'd0, 5'd1, 5'd1, 5'd1};
    src_valid = 3'b001; src_tag = {5'd0, 5'd0, 5'd1}; src_data = {32'h0, 32'h0, 32'h99};
    for (int g = 0; g < 4; g++) tick();
    src_pend = 3'b001;
    tick();
    tick();
    in_valid = 1'b0;
    tick();
    check_output("stats_fwd_cnt", 128'(fwd_cnt), 128'(12));
    check_output("stats_stall_cnt", 128'(stall_cnt), 128'(2));
    rst = 1'b1;
    tick();
    check_output("stats_rst_fwd", 128'(fwd_cnt), 128'(0));
    check_output("stats_rst_stall", 128'(stall_cnt), 128'(0));
    rst = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/operand_forward_unit.md
# operand_forward_unit

Parametrised operand bypass stage for the superscalar issue path. For each of NOPS source operands it compares the operand's register tag against NSRC in-flight result sources (ordered youngest first). It picks the youngest matching result, or the register-file value when nothing matches. A pending (not yet produced) match stalls the issue group. Selected operands are registered behind a valid/ready handshake, giving a one-cycle, stall-capable bypass stage ahead of the ALU lanes.

## Interface
Parameters:
- DWIDTH, `DWIDTH: data width.
- AWIDTH, 5: register tag width.
- NOPS, 4: operand channels per issue group (2 lanes × 2 operands).
- NSRC, 3: forwarding sources; index 0 is the youngest (EX/MEM), higher indices are older.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  issue group present.
- in_ready  out  1  group accepted this cycle when in_valid is also high.
- in_tag  in  NOPS*AWIDTH  operand register numbers; channel i occupies bits [i*AWIDTH +: AWIDTH].
- in_data  in  NOPS*DWIDTH  register-file read values.
- src_valid  in  NSRC  source holds a live register write.
- src_tag  in  NSRC*AWIDTH  destination register of each source.
- src_data  in  NSRC*DWIDTH  result value of each source.
- src_pend  in  NSRC  source result not yet available (load in flight).
- stall  out  1  issue group blocked by a pending match.
- out_valid  out  1  registered operands valid.
- out_ready  in  1  downstream consumes the operands.
- out_data  out  NOPS*DWIDTH  selected operands.
- out_sel  out  NOPS*SELW  per-channel selection code: 0 = register file, k+1 = source k.

## Operation
- Per channel i: hit_k = src_valid[k] && src_tag[k] == in_tag[i] && in_tag[i] != 0.
- Winner is the lowest k with hit_k. With no hit, select in_data[i] with code 0.
- Register 0 is never forwarded: a tag of 0 always selects in_data.
- blocked_i = the winner has src_pend set. An older non-pending match does not override a younger pending one.
- stall = in_valid && OR(blocked_i), combinational.
- in_ready = (!out_valid || out_ready) && !stall.
- Capture when in_valid && in_ready: out_data, out_sel ← selections; out_valid ← 1.
- When out_valid && out_ready and there is no capture: out_valid ← 0. out_data and out_sel hold their last values.
- When out_valid && !out_ready: out_data, out_sel and out_valid hold stable.
- No source is sampled while stalled; selection is re-evaluated combinationally every cycle until no channel is blocked.

## Timing
- Latency: 1 cycle from accepted input to out_valid.
- Throughput: 1 group per cycle when out_ready is held high and there is no stall.
- Simultaneous capture and consume: the output register is overwritten and out_valid stays 1.
- Reset values: out_valid 0, out_data 0, out_sel 0, counters 0.
- Reset mid-operation drops any held group. in_ready may be high on the first cycle after reset.
- stall and in_ready are combinational from the in_* and src_* inputs. There is no combinational path from out_ready to out_data.

## Configuration
- FWD_STATS_EN defined adds two outputs:
  - fwd_cnt (32): accepted channels with a non-zero selection code, summed per capture.
  - stall_cnt (32): cycles with stall high.
  - Both saturate at 32'hFFFF_FFFF and clear on rst.
- Undefined: both ports and their counters are absent; datapath behaviour is identical.

## Structure
- header.vh provides `DWIDTH and the default AWIDTH.
- SELW = $clog2(NSRC+1) is a localparam inside the module.
- Sub-module fwd_select handles one channel: priority match over NSRC sources, producing data, sel and blocked. It is instantiated NOPS times in a generate loop.
- The top level holds the handshake, the output register and the optional counters.

## Test plan
- Tag 5, no source matches, in_data 32'h11 → out_data 32'h11, out_sel 0, out_valid one cycle after acceptance.
- Sources 0 and 2 both tag 5 with data 32'hA0 and 32'hC0 → out_data 32'hA0, out_sel 1 (youngest wins).
- Tag 0 with source 0 tag 0 valid, data 32'hFF; in_data 0 → out_data 0, out_sel 0.
- Source 0 tag 7 pending for 2 cycles with data 32'h77, then not pending → stall and !in_ready for 2 cycles; 3rd cycle accepts; out_data 32'h77.
- out_ready low for 3 cycles with in_valid held → out_data stable, in_ready low, then back-to-back groups accepted at 1 per cycle.
- With FWD_STATS_EN: 4 groups, each with 3 forwarded channels, plus 2 stall cycles → fwd_cnt 12, stall_cnt 2; rst clears both to 0.
